// File: rtl/stack_lifo.sv
// Register-array LIFO stack with a one-cycle registered pop path.
// Supports same-cycle push/pop (top replace, or bypass when empty) and sticky overflow/underflow flags.
module stack_lifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] SP_FULL = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_data;

  // When full, sp's low bits are zero, so the subtraction wraps to the last slot.
  assign top_idx  = sp_q[AW-1:0] - AW'(1);
  assign top_data = mem_q[top_idx];
  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_FULL);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    sp_d      = sp_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    mem_we    = 1'b0;
    mem_waddr = sp_q[AW-1:0];

    if (clr) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (push && pop) begin
      valid_d = 1'b1;
      if (empty) begin
        dout_d = din;
      end else begin
        dout_d    = top_data;
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end
    end else if (push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        sp_d   = sp_q + (AW+1)'(1);
      end
    end else if (pop) begin
      if (empty) begin
        udf_d = 1'b1;
      end else begin
        dout_d  = top_data;
        valid_d = 1'b1;
        sp_d    = sp_q - (AW+1)'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; entries at or above sp are never observable.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign count      = sp_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule

// File: tb/tb_stack_lifo.sv
// Self-checking bench for stack_lifo: queue-based reference stack feeds an expected-pop scoreboard.
module tb_stack_lifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, push, pop;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid;
  logic [6:0] count;
  logic       empty, full, ovf, udf;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] stk   [$];
  logic [7:0] exp_q [$];

  stack_lifo #(.WIDTH(8), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop), .din(din),
    .dout(dout), .dout_valid(dout_valid), .count(count),
    .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One clocked operation: updates the reference stack, queues the expected pop data,
  // then pops the scoreboard when the DUT reports dout_valid.
  task automatic cycle(input string name, input logic p, input logic q, input logic [7:0] d);
    logic       exp_valid;
    logic [7:0] exp_d;
    @(negedge clk);
    push = p; pop = q; din = d;
    exp_valid = 1'b0;
    if (p && q) begin
      exp_valid = 1'b1;
      if (stk.size() == 0) exp_q.push_back(d);
      else begin
        exp_q.push_back(stk[$]);
        stk[$] = d;
      end
    end else if (p) begin
      if (stk.size() < 64) stk.push_back(d);
    end else if (q && stk.size() > 0) begin
      exp_valid = 1'b1;
      exp_q.push_back(stk.pop_back());
    end
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    vectors++;
    if (dout_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL %s dout_valid got %b exp %b", name, dout_valid, exp_valid);
    end
    if (exp_valid && exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      vectors++;
      if (dout !== exp_d) begin
        miscompares++;
        $display("FAIL %s dout got %h exp %h", name, dout, exp_d);
      end
    end
  endtask

  task automatic apply_clr(input logic with_push);
    @(negedge clk);
    clr = 1'b1; push = with_push; din = 8'h99;
    @(posedge clk); #1;
    clr = 1'b0; push = 1'b0;
    stk.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    #3;
    vectors++;
    if ({dout, dout_valid, count, empty, full, ovf, udf} !== {8'h00, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got dout=%h v=%b cnt=%0d e=%b f=%b o=%b u=%b exp 00 0 0 1 0 0 0",
               dout, dout_valid, count, empty, full, ovf, udf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lifo_order;
    cycle("push11", 1, 0, 8'h11);
    cycle("push22", 1, 0, 8'h22);
    cycle("push33", 1, 0, 8'h33);
    vectors++;
    if (count !== 7'd3) begin miscompares++; $display("FAIL lifo_count3 got %0d exp 3", count); end
    cycle("pop33", 0, 1, 8'h00);
    cycle("pop22", 0, 1, 8'h00);
    cycle("pop11", 0, 1, 8'h00);
    cycle("idle_after_pop", 0, 0, 8'h00);
    vectors++;
    if (count !== 7'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL lifo_empty got cnt=%0d e=%b exp 0 1", count, empty);
    end
  endtask

  task automatic test_full_ovf;
    for (int i = 0; i < 64; i++) cycle("fill", 1, 0, 8'(i));
    vectors++;
    if (full !== 1'b1 || count !== 7'd64 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL full_flag got f=%b cnt=%0d o=%b exp 1 64 0", full, count, ovf);
    end
    cycle("push_when_full", 1, 0, 8'hFF);
    vectors++;
    if (ovf !== 1'b1 || count !== 7'd64) begin
      miscompares++;
      $display("FAIL ovf_set got o=%b cnt=%0d exp 1 64", ovf, count);
    end
    cycle("swap_full", 1, 1, 8'hEE);
    vectors++;
    if (count !== 7'd64) begin miscompares++; $display("FAIL swap_full_count got %0d exp 64", count); end
    cycle("pop_after_swap", 0, 1, 8'h00);
    vectors++;
    if (count !== 7'd63 || full !== 1'b0 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL after_full_pop got cnt=%0d f=%b o=%b exp 63 0 1", count, full, ovf);
    end
    apply_clr(1'b1);
    vectors++;
    if ({count, empty, full, ovf, dout_valid, dout} !== {7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE}) begin
      miscompares++;
      $display("FAIL clr_state got cnt=%0d e=%b f=%b o=%b v=%b dout=%h exp 0 1 0 0 0 ee",
               count, empty, full, ovf, dout_valid, dout);
    end
  endtask

  task automatic test_underflow_clr;
    cycle("pop_empty", 0, 1, 8'h00);
    vectors++;
    if (udf !== 1'b1 || count !== 7'd0 || dout !== 8'hEE) begin
      miscompares++;
      $display("FAIL udf_set got u=%b cnt=%0d dout=%h exp 1 0 ee", udf, count, dout);
    end
    apply_clr(1'b0);
    vectors++;
    if (udf !== 1'b0) begin miscompares++; $display("FAIL udf_clr got %b exp 0", udf); end
  endtask

  task automatic test_back_to_back;
    cycle("push0A", 1, 0, 8'h0A);
    cycle("push0B", 1, 0, 8'h0B);
    cycle("swapCC", 1, 1, 8'hCC);
    vectors++;
    if (count !== 7'd2) begin miscompares++; $display("FAIL swap_count got %0d exp 2", count); end
    cycle("popCC", 0, 1, 8'h00);
    cycle("pop0A", 0, 1, 8'h00);
    cycle("bypass5A", 1, 1, 8'h5A);
    vectors++;
    if (count !== 7'd0 || udf !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_state got cnt=%0d u=%b e=%b exp 0 0 1", count, udf, empty);
    end
  endtask

  task automatic test_async_reset;
    cycle("udf_again", 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cycle("push5", 1, 0, 8'(8'h40 + i));
    cycle("pop_before_rst", 0, 1, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({count, dout_valid, ovf, udf, dout} !== {7'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL async_rst got cnt=%0d v=%b o=%b u=%b dout=%h exp 0 0 0 0 00",
               count, dout_valid, ovf, udf, dout);
    end
    @(negedge clk);
    push = 1'b1; din = 8'h77;
    @(posedge clk); #1;
    vectors++;
    if (count !== 7'd0 || dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abort got cnt=%0d v=%b exp 0 0", count, dout_valid);
    end
    @(negedge clk);
    push = 1'b0;
    rst_n = 1'b1;
    stk.delete();
    exp_q.delete();
    cycle("push01", 1, 0, 8'h01);
    cycle("pop01", 0, 1, 8'h00);
    vectors++;
    if (count !== 7'd0) begin miscompares++; $display("FAIL post_rst_count got %0d exp 0", count); end
  endtask

  initial begin
    test_reset();
    test_lifo_order();
    test_full_ovf();
    test_underflow_clr();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_lifo.md
STACK_LIFO -- requirements
Module: stack_lifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter AW, default 6, pointer width; depth = 2^AW entries (64 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous clear of stack contents and flags.
REQ-006 push  input  1  write din onto top of stack this cycle.
REQ-007 pop  input  1  read and remove top of stack this cycle.
REQ-008 din  input  WIDTH  push data.
REQ-009 dout  output  WIDTH  popped data, registered.
REQ-010 dout_valid  output  1  one-cycle pulse, dout holds data from the previous cycle's accepted pop.
REQ-011 count  output  AW+1  current number of stored entries, 0..2^AW.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == 2^AW.
REQ-014 ovf  output  1  sticky, push rejected while full.
REQ-015 udf  output  1  sticky, pop rejected while empty.

Function
REQ-016 Storage SHALL be a 2^AW x WIDTH register array; sp (AW+1 bits) points to next free slot; top entry is mem[sp-1].
REQ-017 Push only, not full: mem[sp] <= din, sp <= sp+1 at the same edge.
REQ-018 Pop only, not empty: dout <= mem[sp-1], sp <= sp-1, dout_valid <= 1 at the same edge; latency 1 cycle from pop sample to dout_valid.
REQ-019 Push and pop, not empty (full included): dout <= mem[sp-1], mem[sp-1] <= din, sp unchanged, dout_valid <= 1.
REQ-020 Push and pop, empty: bypass; dout <= din, dout_valid <= 1, sp stays 0, udf unchanged.
REQ-021 Push only while full: no write, sp unchanged, ovf <= 1.
REQ-022 Pop only while empty: dout unchanged, dout_valid <= 0, sp unchanged, udf <= 1.
REQ-023 dout_valid SHALL be 0 in every cycle not following an accepted pop; dout SHALL hold its last value otherwise.
REQ-024 count SHALL equal sp; empty and full SHALL be combinational decodes of sp.
REQ-025 clr has priority over push and pop: sp <= 0, ovf <= 0, udf <= 0, dout_valid <= 0; dout and array contents unchanged.
REQ-026 sp SHALL never wrap: it never exceeds 2^AW and never goes below 0.
REQ-027 Array contents above sp are don't-care and SHALL never appear on dout.

Reset
REQ-028 rst_n low SHALL immediately force sp=0, dout=0, dout_valid=0, ovf=0, udf=0, independent of clk.
REQ-029 Array contents SHALL not be reset.
REQ-030 Reset asserted mid-operation SHALL abort any push/pop in that cycle; the first edge after rst_n rises operates normally.

Verification
REQ-031 Reset, push 0x11,0x22,0x33, pop x3 -> dout_valid pulses with 0x33,0x22,0x11; empty=1, count=0 after.
REQ-032 Push 64 values 0..63 -> full=1, count=64; 65th push -> ovf=1, count stays 64; pop -> dout=63.
REQ-033 From empty, pop -> udf=1, dout_valid=0, count=0; then clr -> udf=0.
REQ-034 With 0x0A,0x0B stacked, push 0xCC and pop same cycle -> dout=0x0B, count=2; next pop -> dout=0xCC.
REQ-035 From empty, push 0x5A and pop same cycle -> dout=0x5A, dout_valid=1, count=0, udf=0.
REQ-036 Push 5 values, assert rst_n low between edges -> sp, flags, dout_valid clear immediately; after release, push 0x01/pop -> dout=0x01.
